// File: rtl/ospi_flash_pkg.sv
// Shared opcodes, FSM states and status-register bit positions
// for the OSPI flash array model.
package ospi_flash_pkg;

    typedef enum logic [2:0] {
        OP_READ         = 3'd0,
        OP_RDSR         = 3'd1,
        OP_WREN         = 3'd2,
        OP_WRDI         = 3'd3,
        OP_PROGRAM      = 3'd4,
        OP_SECTOR_ERASE = 3'd5,
        OP_CHIP_ERASE   = 3'd6,
        OP_CLRSR        = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PROG,
        ST_ERASE
    } state_e;

    localparam int SR_BUSY = 0;
    localparam int SR_WEL  = 1;
    localparam int SR_ERR  = 2;

endpackage

// File: rtl/ospi_flash_mem.sv
// Single-port flash storage: synchronous write, asynchronous read.
// Cells hold inverted data so power-up zeros read back as erased ones.
module ospi_flash_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] cells [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            cells[addr] <= ~wdata;
        end
    end

    assign rdata = ~cells[addr];

endmodule

// File: rtl/ospi_flash_array.sv
// OSPI flash storage/timing core: write-enable latch, AND-only program,
// multi-cycle program, word-by-word sector/chip erase, status register.
module ospi_flash_array
    import ospi_flash_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int SECTOR_W    = 4,
    parameter int PROG_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs_n,
    input  logic              hold_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              wel,
    output logic              err
);

    localparam int CNT_W = $clog2(PROG_CYCLES + 1);
    localparam logic [ADDR_W-1:0] SEC_MASK =
        {ADDR_W{1'b1}} >> (ADDR_W - SECTOR_W);

    state_e            state;
    op_e               op;
    logic              hold_q;
    logic              chip_q;
    logic              accept;
    logic              last_word;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] wdata_q;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    assign op        = op_e'(cmd_op);
    assign cmd_ready = !cs_n && !hold_q;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state != ST_IDLE);

    // The walker stops at the top of its sector (or of the array).
    assign last_word = chip_q ? (&ptr) : ((ptr & SEC_MASK) == SEC_MASK);

    assign mem_addr  = busy ? ptr : cmd_addr;
    assign mem_we    = !hold_q &&
                       ((state == ST_PROG && cnt == CNT_W'(1)) ||
                        state == ST_ERASE);
    assign mem_wdata = (state == ST_PROG) ? (mem_rdata & wdata_q) : '1;

    ospi_flash_mem #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(mem_wdata),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            hold_q    <= 1'b0;
            chip_q    <= 1'b0;
            cnt       <= '0;
            ptr       <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '1;
            wel       <= 1'b0;
            err       <= 1'b0;
        end else begin
            hold_q <= !hold_n;
            if (!hold_q) begin
                rsp_valid <= 1'b0;
                if (accept && op == OP_RDSR) begin
                    rsp_valid         <= 1'b1;
                    rsp_data          <= '0;
                    rsp_data[SR_BUSY] <= busy;
                    rsp_data[SR_WEL]  <= wel;
                    rsp_data[SR_ERR]  <= err;
                end else if (accept && busy) begin
                    err <= 1'b1;
                end else if (accept) begin
                    unique case (op)
                        OP_READ: begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= mem_rdata;
                        end
                        OP_WREN:  wel <= 1'b1;
                        OP_WRDI:  wel <= 1'b0;
                        OP_CLRSR: err <= 1'b0;
                        OP_PROGRAM: begin
                            if (wel) begin
                                state   <= ST_PROG;
                                cnt     <= CNT_W'(PROG_CYCLES);
                                ptr     <= cmd_addr;
                                wdata_q <= cmd_wdata;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                        OP_SECTOR_ERASE: begin
                            if (wel) begin
                                state  <= ST_ERASE;
                                chip_q <= 1'b0;
                                ptr    <= cmd_addr & ~SEC_MASK;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                        OP_CHIP_ERASE: begin
                            if (wel) begin
                                state  <= ST_ERASE;
                                chip_q <= 1'b1;
                                ptr    <= '0;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end

                unique case (state)
                    ST_PROG: begin
                        if (cnt == CNT_W'(1)) begin
                            state <= ST_IDLE;
                            wel   <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_ERASE: begin
                        if (last_word) begin
                            state <= ST_IDLE;
                            wel   <= 1'b0;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ospi_flash_array.sv
// Directed plus randomized bench for ospi_flash_array against a
// word-array reference model of the flash contents and status bits.
module tb_ospi_flash_array;

    localparam logic [2:0] READ  = 3'd0;
    localparam logic [2:0] RDSR  = 3'd1;
    localparam logic [2:0] WREN  = 3'd2;
    localparam logic [2:0] WRDI  = 3'd3;
    localparam logic [2:0] PROG  = 3'd4;
    localparam logic [2:0] SERA  = 3'd5;
    localparam logic [2:0] CERA  = 3'd6;
    localparam logic [2:0] CLRSR = 3'd7;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cs_n = 1'b1;
    logic       hold_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_addr = 8'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       wel;
    logic       err;

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;

    logic [7:0] mm [256];
    logic       wel_m;
    logic       err_m;

    ospi_flash_array dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cs_n     (cs_n),
        .hold_n   (hold_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .busy     (busy),
        .wel      (wel),
        .err      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] d);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic read_chk(input logic [7:0] a, input string tag);
        send(READ, a, 8'h00);
        chk({tag, "_vld"}, {31'd0, rsp_valid}, 32'd1);
        chk(tag, {24'd0, rsp_data}, {24'd0, mm[a]});
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic program_word(input logic [7:0] a, input logic [7:0] d);
        int n;
        send(WREN, 8'h00, 8'h00);
        send(PROG, a, d);
        wait_idle(n);
        chk("prog_busy_len", n, 4);
        mm[a] = mm[a] & d;
        chk("prog_wel_clr", {31'd0, wel}, 32'd0);
    endtask

    initial begin
        int n;
        int ne;
        int unsigned c0;
        logic [7:0] a;
        logic [7:0] d;

        for (int i = 0; i < 256; i++) mm[i] = 8'hFF;
        wel_m = 1'b0;
        err_m = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {24'd0, rsp_data}, 32'hFF);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wel", {31'd0, wel}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        reset_n = 1'b1;
        cs_n = 1'b0;
        @(negedge clk);

        read_chk(8'h10, "read_erased");
        send(RDSR, 8'h00, 8'h00);
        chk("rdsr_vld", {31'd0, rsp_valid}, 32'd1);
        chk("rdsr_clean", {24'd0, rsp_data}, 32'h00);

        send(PROG, 8'h10, 8'h3C);
        err_m = 1'b1;
        chk("prog_no_wel_err", {31'd0, err}, {31'd0, err_m});
        chk("prog_no_wel_busy", {31'd0, busy}, 32'd0);
        read_chk(8'h10, "prog_no_wel_data");
        send(CLRSR, 8'h00, 8'h00);
        chk("clrsr_no_rsp", {31'd0, rsp_valid}, 32'd0);
        err_m = 1'b0;
        send(RDSR, 8'h00, 8'h00);
        chk("rdsr_after_clr", {24'd0, rsp_data}, 32'h00);

        send(WREN, 8'h00, 8'h00);
        chk("wren_wel", {31'd0, wel}, 32'd1);
        send(WRDI, 8'h00, 8'h00);
        chk("wrdi_wel", {31'd0, wel}, 32'd0);

        program_word(8'h20, 8'hF0);
        program_word(8'h20, 8'h3C);
        send(READ, 8'h20, 8'h00);
        chk("and_program", {24'd0, rsp_data}, 32'h30);

        program_word(8'h1F, 8'h5A);
        program_word(8'h30, 8'hA5);
        program_word(8'h27, 8'h12);
        send(WREN, 8'h00, 8'h00);
        send(SERA, 8'h25, 8'h00);
        wait_idle(n);
        chk("sector_busy_len", n, 16);
        chk("sector_wel_clr", {31'd0, wel}, 32'd0);
        for (int i = 8'h20; i <= 8'h2F; i++) mm[i] = 8'hFF;
        read_chk(8'h20, "sector_lo");
        read_chk(8'h27, "sector_mid");
        read_chk(8'h2F, "sector_hi");
        read_chk(8'h1F, "below_sector");
        read_chk(8'h30, "above_sector");

        for (int it = 0; it < 24; it++) begin
            a = 8'($urandom_range(0, 255));
            d = 8'($urandom);
            case ($urandom_range(0, 2))
                0: program_word(a, d);
                1: read_chk(a, "rnd_read");
                default: begin
                    send(PROG, a, d);
                    chk("rnd_no_wel_err", {31'd0, err}, 32'd1);
                    read_chk(a, "rnd_no_wel_data");
                    send(CLRSR, 8'h00, 8'h00);
                    chk("rnd_clrsr", {31'd0, err}, 32'd0);
                end
            endcase
        end

        for (int i = 0; i < 16; i++) begin
            program_word(8'(8'h40 + i), 8'($urandom) & 8'h7F);
        end
        send(WREN, 8'h00, 8'h00);
        send(SERA, 8'h4A, 8'h00);
        c0 = cyc;
        chk("erase_busy", {31'd0, busy}, 32'd1);
        send(RDSR, 8'h00, 8'h00);
        chk("rdsr_mid_erase", {24'd0, rsp_data}, 32'h03);
        send(READ, 8'h41, 8'h00);
        chk("read_mid_erase_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("read_mid_erase_err", {31'd0, err}, 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        ne = int'(cyc - c0);
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_wel", {31'd0, wel}, 32'd0);
        chk("rst_mid_err", {31'd0, err}, 32'd0);
        for (int i = 0; i < ne && i < 16; i++) mm[8'h40 + i] = 8'hFF;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) read_chk(8'(8'h40 + i), "rst_mid_data");

        d = 8'($urandom);
        send(WREN, 8'h00, 8'h00);
        send(PROG, 8'h60, d);
        hold_n = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            chk("hold_ready", {31'd0, cmd_ready},
                (n >= 1 && n <= 5) ? 32'd0 : 32'd1);
            n++;
            @(negedge clk);
            if (n == 5) hold_n = 1'b1;
        end
        hold_n = 1'b1;
        chk("hold_busy_len", n, 9);
        mm[8'h60] = mm[8'h60] & d;
        read_chk(8'h60, "hold_prog_data");

        send(WREN, 8'h00, 8'h00);
        send(CERA, 8'h00, 8'h00);
        wait_idle(n);
        chk("chip_busy_len", n, 256);
        for (int i = 0; i < 256; i++) mm[i] = 8'hFF;
        read_chk(8'h00, "chip_first");
        read_chk(8'h60, "chip_mid");
        read_chk(8'hFF, "chip_last");
        send(RDSR, 8'h00, 8'h00);
        chk("rdsr_final", {24'd0, rsp_data}, 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
